// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//   Drives one shared 7-segment bus for two common-segment displays. It keeps a
//   two-digit key history: each new key moves the right digit to the left and
//   takes the right position. The block alternates between the right and left
//   displays and inserts a blanking gap between them to prevent ghosting.
//
//   Scan order: SHOW_R -> BLANK_RL -> SHOW_L -> BLANK_LR -> SHOW_R.
//   When BLANK_CYCLES == 0 the blank states are skipped, so the order is
//   SHOW_R <-> SHOW_L.
//
//   Optional feature macro: BLANK_INVALID_EN
//     defined   : a display whose digit was never written (or was cleared)
//                 stays dark during its SHOW phase.
//     undefined : the enables ignore the valid bits, so empty digits show "0".
//
// Parameters
//   HOLD_CYCLES   clk cycles each display is lit per phase (>=1)
//   BLANK_CYCLES  clk cycles both displays are off between phases (>=0)
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   key_valid    in   single-cycle strobe; key holds a new keypress
//   key[3:0]     in   hex code of the pressed key
//   clear        in   synchronous clear of the digit history
//   digit[3:0]   out  code for the external seven_segment decoder
//   on1          out  left display enable, active-high
//   on2          out  right display enable, active-high
//   fsm_state    out  current scan state (debug)
//   digit_valid  out  {val_l, val_r} history valid bits (debug)
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int HOLD_CYCLES  = 40,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       on1,
  output logic       on2,
  output logic [1:0] fsm_state,
  output logic [1:0] digit_valid
);

  localparam int MAX_LEN = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  // With no blank phase the blank states are unreachable, so this value is unused.
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    SHOW_R   = 2'd0,
    BLANK_RL = 2'd1,
    SHOW_L   = 2'd2,
    BLANK_LR = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_last;
  logic [3:0]    dig_l, dig_r;
  logic          val_l, val_r;
  logic          en_l, en_r;

  assign fsm_state   = state;
  assign digit_valid = {val_l, val_r};

`ifdef BLANK_INVALID_EN
  assign en_l = val_l;
  assign en_r = val_r;
`else
  assign en_l = 1'b1;
  assign en_r = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Scan FSM: state register plus the phase counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SHOW_R;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    cnt_last  = HOLD_LAST;
    if (state == BLANK_RL || state == BLANK_LR) cnt_last = BLANK_LAST;
    if (cnt == cnt_last) begin
      cnt_nxt = '0;
      case (state)
        SHOW_R:   state_nxt = (BLANK_CYCLES == 0) ? SHOW_L : BLANK_RL;
        BLANK_RL: state_nxt = SHOW_L;
        SHOW_L:   state_nxt = (BLANK_CYCLES == 0) ? SHOW_R : BLANK_LR;
        BLANK_LR: state_nxt = SHOW_R;
        default:  state_nxt = SHOW_R;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Key history. A press always wins over clear. When both occur together,
  // the left digit is cleared instead of inheriting the old right digit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_l <= 4'h0;
      dig_r <= 4'h0;
      val_l <= 1'b0;
      val_r <= 1'b0;
    end else if (key_valid) begin
      dig_l <= clear ? 4'h0 : dig_r;
      val_l <= clear ? 1'b0 : val_r;
      dig_r <= key;
      val_r <= 1'b1;
    end else if (clear) begin
      dig_l <= 4'h0;
      dig_r <= 4'h0;
      val_l <= 1'b0;
      val_r <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, one cycle behind the scan state. Only one enable is
  // ever driven from a given state, so on1 and on2 cannot overlap.
  // Reset forces both enables low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'h0;
      on1   <= 1'b0;
      on2   <= 1'b0;
    end else begin
      case (state)
        SHOW_R: begin
          on1   <= 1'b0;
          on2   <= en_r;
          digit <= dig_r;
        end
        SHOW_L: begin
          on1   <= en_l;
          on2   <= 1'b0;
          digit <= dig_l;
        end
        default: begin
          on1 <= 1'b0;
          on2 <= 1'b0;
        end
      endcase
    end
  end

endmodule
